iter_divider: RTL

Iterative radix-2 restoring divider that answers the MDU's divide requests. It takes operands on a valid/ready request channel and returns quotient and remainder on a valid/ready response channel. Leading-zero skipping gives data-dependent latency. The MDU instantiates it in its M2 stage for div.w/div.wu/mod.w/mod.wu, and uses a synchronous reset as the flush.

---
 rtl/iter_divider.sv | 130 +++++++++++++
 1 files changed

// File: rtl/iter_divider.sv
// iter_divider: iterative radix-2 restoring divider, valid/ready in and out, leading-zero early-out.
module iter_divider #(
    parameter logic EARLY_OUT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        div_valid,
    output logic        div_ready,
    input  logic        div_signed_i,
    input  logic [31:0] Z_i,
    input  logic [31:0] D_i,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] q_o,
    output logic [31:0] s_o
);
    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;
    state_t      state_q, state_d;
    logic        sg_q, sg_d, qneg_q, qneg_d, sneg_q, sneg_d;
    logic [31:0] z_q, z_d, d_q, d_d, q_q, q_d, r_q, r_d, qo_q, qo_d, so_q, so_d;
    logic [5:0]  cnt_q, cnt_d, clz, k;
    logic [31:0] az, ad;
    logic [32:0] rp;
    logic        dz, early, ge;
    assign az    = (sg_q && z_q[31]) ? -z_q : z_q;
    assign ad    = (sg_q && d_q[31]) ? -d_q : d_q;
    assign dz    = d_q == '0;
    assign early = EARLY_OUT && az < ad;
    assign k     = EARLY_OUT ? clz : 6'd0;
    assign rp    = {r_q, z_q[31]};
    assign ge    = rp >= {1'b0, d_q};
    assign q_o   = qo_q;
    assign s_o   = so_q;
    always_comb begin
        clz = 6'd32;
        for (int i = 0; i < 32; i++) if (az[i]) clz = 6'(31 - i);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = div_valid ? PREP : IDLE;
            PREP:    state_d = (dz || early) ? FIX : CALC;
            CALC:    state_d = (cnt_q == 6'd1) ? FIX : CALC;
            FIX:     state_d = DONE;
            DONE:    state_d = res_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        div_ready = state_q == IDLE;
        res_valid = state_q == DONE;
    end
    always_comb begin
        sg_d   = sg_q;
        qneg_d = qneg_q;
        sneg_d = sneg_q;
        z_d    = z_q;
        d_d    = d_q;
        q_d    = q_q;
        r_d    = r_q;
        cnt_d  = cnt_q;
        qo_d   = qo_q;
        so_d   = so_q;
        case (state_q)
            IDLE: if (div_valid) begin
                sg_d   = div_signed_i;
                z_d    = Z_i;
                d_d    = D_i;
                qneg_d = div_signed_i & (Z_i[31] ^ D_i[31]);
                sneg_d = div_signed_i & Z_i[31];
            end
            PREP: if (dz) begin
                // divide-by-zero result is returned raw, so suppress the sign fixup
                q_d    = '1;
                r_d    = z_q;
                qneg_d = 1'b0;
                sneg_d = 1'b0;
            end else if (early) begin
                q_d = '0;
                r_d = az;
            end else begin
                z_d   = az << k;
                d_d   = ad;
                q_d   = '0;
                r_d   = '0;
                cnt_d = 6'd32 - k;
            end
            CALC: begin
                r_d   = ge ? 32'(rp - {1'b0, d_q}) : rp[31:0];
                q_d   = {q_q[30:0], ge};
                z_d   = z_q << 1;
                cnt_d = cnt_q - 6'd1;
            end
            FIX: begin
                qo_d = qneg_q ? -q_q : q_q;
                so_d = sneg_q ? -r_q : r_q;
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sg_q   <= 1'b0;
            qneg_q <= 1'b0;
            sneg_q <= 1'b0;
            z_q    <= '0;
            d_q    <= '0;
            q_q    <= '0;
            r_q    <= '0;
            cnt_q  <= '0;
            qo_q   <= '0;
            so_q   <= '0;
        end else begin
            sg_q   <= sg_d;
            qneg_q <= qneg_d;
            sneg_q <= sneg_d;
            z_q    <= z_d;
            d_q    <= d_d;
            q_q    <= q_d;
            r_q    <= r_d;
            cnt_q  <= cnt_d;
            qo_q   <= qo_d;
            so_q   <= so_d;
        end
    end
endmodule
